// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: MemOp encodings,
// FSM state encoding and the MemOp legality check.
package mem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic memop_legal(input logic [2:0] memop);
        logic legal;
        case (memop)
            MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated write
// data, load extraction with sign/zero extension, and alignment checking.
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  memop,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rword[{addr_lo, 3'b000} +: 8];
    assign sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    // memop[2] selects zero extension; memop[1:0] gives the access size.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_al  = 32'h0;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        case (memop[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_al  = {4{wdata[7:0]}};
                rdata_ext = memop[2] ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            2'b01: begin
                misalign  = addr_lo[0];
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al  = {2{wdata[15:0]}};
                rdata_ext = memop[2] ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            2'b10: begin
                misalign  = (addr_lo != 2'b00);
                byte_en   = 4'b1111;
                wdata_al  = wdata;
                rdata_ext = rword;
            end
            default: begin
                byte_en   = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data bus: valid/ready request and
// response channels, programmable wait states, byte-lane memory.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 15,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_t          state_reg;
    logic [3:0]      wait_cnt_reg;
    logic [31:0]     addr_reg;
    logic [31:0]     wdata_reg;
    logic            we_reg;
    logic [2:0]      memop_reg;
    logic            req_ready_reg;
    logic            resp_valid_reg;
    logic            resp_err_reg;
    logic [31:0]     resp_rdata_reg;

    logic [31:0]           rword;
    logic [ADDR_WIDTH-1:0] rd_index;
    logic [ADDR_WIDTH-1:0] wr_index;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_al;
    logic [31:0]           rdata_ext;
    logic                  misalign;
    logic                  range_err;
    logic                  access_err;
    logic                  commit;
    logic                  do_write;

    // In IDLE the read port looks at the incoming address so the word is
    // already registered when a zero-wait request commits.
    assign rd_index = (state_reg == IDLE) ? req_addr[ADDR_WIDTH+1:2] : addr_reg[ADDR_WIDTH+1:2];
    assign wr_index = addr_reg[ADDR_WIDTH+1:2];

    dmem_lane_align u_lane_align (
        .addr_lo   (addr_reg[1:0]),
        .memop     (memop_reg),
        .wdata     (wdata_reg),
        .rword     (rword),
        .byte_en   (byte_en),
        .wdata_al  (wdata_al),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    assign range_err  = |addr_reg[31:ADDR_WIDTH+2];
    assign access_err = misalign | range_err | ~memop_legal(memop_reg);
    assign commit     = (state_reg == WAIT) && (wait_cnt_reg == 4'd0);
    assign do_write   = commit && we_reg && !access_err && !reset;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk) begin
            if (do_write && byte_en[gi]) begin
                lane_mem[wr_index] <= wdata_al[gi*8 +: 8];
            end
            rd_byte_reg <= lane_mem[rd_index];
        end

        assign rword[gi*8 +: 8] = rd_byte_reg;
    end

    // The counter covers the wait states plus the commit edge, so WAIT is
    // occupied WAIT_CYCLES+1 cycles and the response follows accordingly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= 4'd0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= 1'b0;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
            we_reg         <= 1'b0;
            memop_reg      <= MEMOP_W;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        we_reg        <= req_we;
                        memop_reg     <= req_memop;
                        wait_cnt_reg  <= 4'(WAIT_CYCLES);
                        req_ready_reg <= 1'b0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (commit) begin
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= access_err;
                        resp_rdata_reg <= (access_err || we_reg) ? 32'h0 : rdata_ext;
                        state_reg      <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        resp_rdata_reg <= 32'h0;
                        resp_err_reg   <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule
